// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: the fetch unit is the master, the memory the slave.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_valid;
    logic [15:0]       imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Processor front end: PC, instruction fetch over req/valid, issue strobe and execute window.
// Optional single-step input STEP is enabled by defining IFU_SINGLE_STEP_EN.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       EXEC_CYCLES = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               EXEC,
`ifdef IFU_SINGLE_STEP_EN
    input  logic               STEP,
`endif
    input  logic               PC_load,
    input  logic [ADDR_W-1:0]  branch_target,
    instr_fetch_unit_if.master imem,
    output logic [15:0]        COMMAND,
    output logic               cmd_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               running,
    output logic [15:0]        instr_count
);

    typedef enum logic [1:0] {StHalt, StFetch, StIssue, StExecute} state_e;

    localparam logic [3:0]        ExecInit = 4'(EXEC_CYCLES);
    localparam logic [ADDR_W-1:0] PcOne    = {{(ADDR_W - 1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target_q;
    logic [15:0]       command_q;
    logic [15:0]       count_q;
    logic [3:0]        cnt_q;
    logic              cmd_valid_q;
    logic              req_q;
    logic              running_q;
    logic              halt_pending_q;
    logic              take_q;
    logic              exec_q;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_exec_d;
    logic              halt_pending_d;
    logic              exec_rise;
    logic              step_rise;
    logic              is_hlt;

    assign exec_rise = EXEC & ~exec_q;

`ifdef IFU_SINGLE_STEP_EN
    logic step_q;
    assign step_rise = STEP & ~step_q;
`else
    assign step_rise = 1'b0;
`endif

    assign is_hlt = (command_q[15:14] == 2'b11) && (command_q[7:4] == 4'b1111);

    always_comb begin
        pc_inc         = pc_q + PcOne;
        // A branch asserted in the final execute cycle still wins over an earlier one.
        pc_exec_d      = PC_load ? branch_target : (take_q ? target_q : pc_inc);
        halt_pending_d = halt_pending_q ^ exec_rise;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q        <= StHalt;
            pc_q           <= RESET_PC;
            target_q       <= '0;
            command_q      <= 16'h0000;
            count_q        <= 16'h0000;
            cnt_q          <= 4'd0;
            cmd_valid_q    <= 1'b0;
            req_q          <= 1'b0;
            running_q      <= 1'b0;
            halt_pending_q <= 1'b0;
            take_q         <= 1'b0;
            exec_q         <= 1'b0;
`ifdef IFU_SINGLE_STEP_EN
            step_q         <= 1'b0;
`endif
        end else begin
            exec_q      <= EXEC;
`ifdef IFU_SINGLE_STEP_EN
            step_q      <= STEP;
`endif
            cmd_valid_q <= 1'b0;
            unique case (state_q)
                StHalt: begin
                    if (exec_rise || step_rise) begin
                        state_q        <= StFetch;
                        req_q          <= 1'b1;
                        running_q      <= 1'b1;
                        // EXEC wins for free run; a lone STEP pre-arms the halt.
                        halt_pending_q <= ~exec_rise;
                    end
                end
                StFetch: begin
                    halt_pending_q <= halt_pending_d;
                    if (imem.imem_valid) begin
                        command_q   <= imem.imem_rdata;
                        state_q     <= StIssue;
                        req_q       <= 1'b0;
                        cmd_valid_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (is_hlt) begin
                        pc_q           <= pc_inc;
                        count_q        <= count_q + 16'd1;
                        state_q        <= StHalt;
                        running_q      <= 1'b0;
                        halt_pending_q <= 1'b0;
                    end else begin
                        cnt_q          <= ExecInit;
                        take_q         <= 1'b0;
                        state_q        <= StExecute;
                        halt_pending_q <= halt_pending_d;
                    end
                end
                StExecute: begin
                    if (PC_load) begin
                        take_q   <= 1'b1;
                        target_q <= branch_target;
                    end
                    if (cnt_q == 4'd1) begin
                        pc_q           <= pc_exec_d;
                        count_q        <= count_q + 16'd1;
                        halt_pending_q <= 1'b0;
                        if (halt_pending_d) begin
                            state_q   <= StHalt;
                            running_q <= 1'b0;
                        end else begin
                            state_q <= StFetch;
                            req_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q          <= cnt_q - 4'd1;
                        halt_pending_q <= halt_pending_d;
                    end
                end
                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req_q;
    assign COMMAND        = command_q;
    assign cmd_valid      = cmd_valid_q;
    assign pc_out         = pc_q;
    assign running        = running_q;
    assign instr_count    = count_q;

endmodule
